// File: rtl/formula_arbiter.sv
// -----------------------------------------------------------------------------
// formula_arbiter
//   Shares one pipelined formula unit among NREQ requesters. A round-robin
//   arbiter picks at most one requester per cycle, its operands are registered
//   and sent to the formula unit, and a tag pipe that runs alongside the unit
//   labels each returning result with its requester id. Tagged results go into
//   a show-ahead result FIFO. A credit counter limits how much work can be in
//   flight, so every returning result is guaranteed a free FIFO slot.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready is one-hot or 0)
//   req_a/b/c/d            packed operands, requester i at [i*N +: N]
//   f_valid, f_a..f_d      issue strobe and operands to the formula unit
//   f_o_valid, f_q         result strobe and value from the formula unit
//   rsp_valid/rsp_ready    result handshake; rsp_id/rsp_q show the FIFO head
//   busy                   work in flight or results buffered
//   err                    sticky tag/result misalignment flag
// -----------------------------------------------------------------------------
module formula_arbiter #(
    parameter int N          = 8,
    parameter int NREQ       = 4,
    parameter int LAT        = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    input  logic [NREQ*N-1:0]         req_c,
    input  logic [NREQ*N-1:0]         req_d,
    output logic                      f_valid,
    output logic [N-1:0]              f_a,
    output logic [N-1:0]              f_b,
    output logic [N-1:0]              f_c,
    output logic [N-1:0]              f_d,
    input  logic                      f_o_valid,
    input  logic [N-1:0]              f_q,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_q,
    output logic                      busy,
    output logic                      err
);

    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]     ptr_reg;
    logic [CW-1:0]      credits_reg;
    logic [IDW-1:0]     grant_id;
    logic               grant_found;
    logic               issue;
    logic [N-1:0]       sel_a, sel_b, sel_c, sel_d;

    logic               f_valid_reg;
    logic [N-1:0]       f_a_reg, f_b_reg, f_c_reg, f_d_reg;
    logic [IDW-1:0]     tag_reg;

    logic               tag_v_reg  [LAT];
    logic [IDW-1:0]     tag_id_reg [LAT];
    logic               tag_any;
    logic               err_reg;

    logic [IDW+N-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               push;
    logic               pop;

    // ---------------- round-robin arbitration ----------------
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // No grant without a credit; rstn gating keeps req_ready low during reset.
    assign issue = rstn && (credits_reg != '0) && grant_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = issue && (grant_id == IDW'(gi));
        end
    endgenerate

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        sel_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_a = req_a[k*N +: N];
                sel_b = req_b[k*N +: N];
                sel_c = req_c[k*N +: N];
                sel_d = req_d[k*N +: N];
            end
        end
    end

    // ---------------- pointer, issue register ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_reg     <= '0;
            f_valid_reg <= 1'b0;
            f_a_reg     <= '0;
            f_b_reg     <= '0;
            f_c_reg     <= '0;
            f_d_reg     <= '0;
            tag_reg     <= '0;
        end else begin
            f_valid_reg <= issue;
            if (issue) begin
                ptr_reg <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
                f_a_reg <= sel_a;
                f_b_reg <= sel_b;
                f_c_reg <= sel_c;
                f_d_reg <= sel_d;
                tag_reg <= grant_id;
            end
        end
    end

    assign f_valid = f_valid_reg;
    assign f_a     = f_a_reg;
    assign f_b     = f_b_reg;
    assign f_c     = f_c_reg;
    assign f_d     = f_d_reg;

    // ---------------- tag pipe (mirrors formula latency) ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) begin
                tag_v_reg[k]  <= 1'b0;
                tag_id_reg[k] <= '0;
            end
        end else begin
            tag_v_reg[0]  <= f_valid_reg;
            tag_id_reg[0] <= tag_reg;
            for (int k = 1; k < LAT; k++) begin
                tag_v_reg[k]  <= tag_v_reg[k-1];
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tag_any = tag_any | tag_v_reg[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_reg <= 1'b0;
        end else if (tag_v_reg[LAT-1] != f_o_valid) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

    // ---------------- result FIFO (show-ahead, asynchronous head read) -------
    // The head must be visible the cycle after the write, so the storage is
    // read combinationally; at this depth it maps to distributed RAM.
    assign pop  = rsp_valid && rsp_ready;
    // Credits make overflow impossible in normal operation; the guard only
    // protects FIFO state when a stray f_o_valid arrives (err case).
    assign push = f_o_valid && ((count_reg != CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {tag_id_reg[LAT-1], f_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rsp_valid       = (count_reg != '0);
    assign {rsp_id, rsp_q} = mem[rd_ptr_reg];

    // ---------------- credits ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits_reg <= CW'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credits_reg <= credits_reg - CW'(1);
                2'b01:   credits_reg <= credits_reg + CW'(1);
                default: credits_reg <= credits_reg;
            endcase
        end
    end

    assign busy = tag_any | f_valid_reg | rsp_valid;

endmodule

// File: tb/tb_formula_arbiter.sv
// -----------------------------------------------------------------------------
// tb_formula_arbiter
//   Drives randomized and directed traffic into formula_arbiter, emulates the
//   external formula unit, and checks responses through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_formula_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int LAT  = 5;
    localparam int FD   = 8;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a, req_b, req_c, req_d;
    logic              f_valid;
    logic [N-1:0]      f_a, f_b, f_c, f_d;
    logic              f_o_valid;
    logic [N-1:0]      f_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_q;
    logic              busy;
    logic              err;

    formula_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .f_valid(f_valid), .f_a(f_a), .f_b(f_b), .f_c(f_c), .f_d(f_d),
        .f_o_valid(f_o_valid), .f_q(f_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int issues     = 0;

    // Reference formula: plain integer arithmetic, then clamp to N-bit signed.
    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d);
        longint sa, sb, sc, sd, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        sd = longint'($signed(d));
        v  = (sa - sb) * (1 + 3 * sc) - 4 * sd;
        v  = v >>> 1;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v[N-1:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- formula unit model ----------------
    logic           fp_v [LAT];
    logic [N-1:0]   fp_q [LAT];
    logic           inject;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) fp_v[k] <= 1'b0;
        end else begin
            fp_v[0] <= f_valid;
            fp_q[0] <= ref_q(f_a, f_b, f_c, f_d);
            for (int k = 1; k < LAT; k++) begin
                fp_v[k] <= fp_v[k-1];
                fp_q[k] <= fp_q[k-1];
            end
        end
    end

    assign f_o_valid = fp_v[LAT-1] | inject;
    assign f_q       = fp_q[LAT-1];

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [1:0]   id;
        logic [N-1:0] q;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            m_e;
    int              rr_ptr  = 0;
    int              m_idx;
    logic [NREQ-1:0] m_exp_ready;
    logic            chk_en  = 1'b1;
    logic            hold_prev = 1'b0;
    logic [1:0]      hold_id;
    logic [N-1:0]    hold_q;

    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            exp_q.delete();
            rr_ptr    = 0;
            hold_prev = 1'b0;
        end else if (chk_en) begin
            // expected grant: credits = depth minus responses still owed
            m_exp_ready = '0;
            if (FD - exp_q.size() > 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (rr_ptr + k) % NREQ;
                    if (req_valid[m_idx]) begin
                        m_exp_ready[m_idx] = 1'b1;
                        break;
                    end
                end
            end
            chk("req_ready", req_ready, m_exp_ready);

            if (hold_prev) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_id", rsp_id, hold_id);
                chk("rsp_hold_q", rsp_q, hold_q);
            end

            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m_e.id = 2'(i);
                    m_e.q  = ref_q(req_a[i*N +: N], req_b[i*N +: N],
                                   req_c[i*N +: N], req_d[i*N +: N]);
                    exp_q.push_back(m_e);
                    rr_ptr = (i + 1) % NREQ;
                    issues++;
                end
            end

            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got id=%0d q=%0d, required no response (t=%0t)",
                             rsp_id, rsp_q, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, m_e.id);
                    chk("rsp_q", rsp_q, m_e.q);
                end
            end

            hold_prev = rsp_valid && !rsp_ready;
            hold_id   = rsp_id;
            hold_q    = rsp_q;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic rand_ops();
        req_a = $urandom;
        req_b = $urandom;
        req_c = $urandom;
        req_d = $urandom;
    endtask

    task automatic do_reset();
        step();
        rstn      = 1'b0;
        req_valid = '0;
        step();
        rstn      = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        #3;
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_f_valid"}, f_valid, 0);
        chk({tag, "_f_a"}, f_a, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic drain(input string tag);
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int w = 0; w < 60 && exp_q.size() != 0; w++) step();
        step();
        #3;
        chk({tag, "_drain_left"}, exp_q.size(), 0);
        chk({tag, "_drain_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_drain_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int base;
        rstn      = 1'b0;
        inject    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        step();
        step();
        rstn = 1'b1;
        chk_reset_state("rst0");

        // 1: single request from requester 2, latency check
        step();
        rand_ops();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        req_a[2*N +: N] = 8'd10;
        req_b[2*N +: N] = 8'd4;
        req_c[2*N +: N] = 8'd1;
        req_d[2*N +: N] = 8'd2;
        step();
        req_valid = '0;
        #3;
        chk("t1_f_valid", f_valid, 1);
        chk("t1_f_a", f_a, 10);
        chk("t1_busy", busy, 1);
        for (int k = 2; k <= 7; k++) begin
            step();
            #3;
            chk("t1_rsp_valid_timing", rsp_valid, (k == 7) ? 1 : 0);
            if (k == 7) begin
                chk("t1_rsp_id", rsp_id, 2);
                chk("t1_rsp_q", rsp_q, 8);
            end
        end
        drain("t1");

        // 2: all requesters, consumer always ready
        step();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rand_ops();
            #3;
            chk("t2_credit_never_zero", (req_ready != 0) ? 1 : 0, 1);
            step();
        end
        drain("t2");

        // 3: consumer stalled -> exactly FD issues, then release
        step();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        base = issues;
        for (int k = 0; k < 14; k++) begin
            rand_ops();
            step();
        end
        #3;
        chk("t3_issue_count", issues - base, FD);
        chk("t3_ready_blocked", req_ready, 0);
        step();
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            step();
        end
        drain("t3");

        // random mix
        for (int k = 0; k < 300; k++) begin
            step();
            req_valid = NREQ'($urandom);
            rand_ops();
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain("rnd");

        // 4: saturation on both rails
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[1*N +: N] = 8'd127;
        req_b[1*N +: N] = 8'h80;
        req_c[1*N +: N] = 8'd127;
        req_d[1*N +: N] = 8'd0;
        step();
        req_a[1*N +: N] = 8'h80;
        req_b[1*N +: N] = 8'd127;
        req_c[1*N +: N] = 8'd127;
        req_d[1*N +: N] = 8'd0;
        step();
        req_valid = '0;
        for (int w = 0; w < 20; w++) begin
            #3;
            if (rsp_valid) break;
            step();
        end
        chk("t4_wait_rsp", rsp_valid, 1);
        chk("t4_q_pos_sat", rsp_q, 8'h7f);
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #3;
        chk("t4_second_valid", rsp_valid, 1);
        chk("t4_q_neg_sat", rsp_q, 8'h80);
        drain("t4");

        // 5: reset with three issues in flight
        step();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        rand_ops();
        step();
        rand_ops();
        step();
        rand_ops();
        step();
        rstn      = 1'b0;
        req_valid = '0;
        step();
        rstn = 1'b1;
        chk_reset_state("t5_rst");
        for (int k = 0; k < 12; k++) begin
            step();
            #3;
            chk("t5_no_stale_rsp", rsp_valid, 0);
        end
        step();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        base = issues;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            step();
        end
        #3;
        chk("t5_credits_restored", issues - base, FD);
        drain("t5");

        // 6: stray f_o_valid -> sticky err until reset
        #3;
        chk("t6_err_before", err, 0);
        step();
        chk_en = 1'b0;
        rsp_ready = 1'b0;
        step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("t6_err_sticky", err, 1);
            step();
        end
        rstn = 1'b0;
        step();
        rstn   = 1'b1;
        chk_en = 1'b1;
        chk_reset_state("t6_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
